hazard_ctrl: RTL and testbench

//  ID-stage hazard/stall controller for the 5-stage MIPS pipeline.

---
 rtl/hazard_ctrl.sv | 118 +++++++++++
 tb/tb_hazard_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: load-use / mfc0-use bubbles, MDU busy sequencing
// and wrong-path flushes for taken branches resolved in EX.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_md_start,
    input  logic        id_md_isdiv,
    input  logic        id_md_read,
    input  logic [4:0]  ex_rw,
    input  logic        ex_regWr,
    input  logic [1:0]  ex_memtoreg,
    input  logic [2:0]  ex_cp0op,
    input  logic        ex_branch_taken,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_cycles
);

    typedef enum logic {IDLE = 1'b0, MD_BUSY = 1'b1} state_t;

    state_t             st;
    state_t             st_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               md_done_q;
    logic               md_done_nxt;

    logic               dep;
    logic               lu;
    logic               mdh;
    logic               stall;
    logic               md_go;

    // Hazards the EX forwarding path cannot cover: the producer's value is not
    // available until MEM (load, mfc0) or the MDU result is still in flight.
    assign dep   = (ex_rw != 5'd0) &&
                   ((id_uses_rs && (ex_rw == id_rs)) || (id_uses_rt && (ex_rw == id_rt)));
    assign lu    = dep && ((ex_regWr && (ex_memtoreg == 2'd1)) || (ex_cp0op == 3'b001));
    assign mdh   = (st == MD_BUSY) && (id_md_read || id_md_start);
    assign stall = lu || mdh;
    assign md_go = (st == IDLE) && id_md_start && !ex_branch_taken && !stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st           <= IDLE;
            cnt          <= '0;
            md_done_q    <= 1'b0;
            stall_cycles <= '0;
        end else begin
            st        <= st_nxt;
            cnt       <= cnt_nxt;
            md_done_q <= md_done_nxt;
            if (pc_stall && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
        end
    end

    // The busy window runs regardless of stalls or flushes: the issued op is older.
    always_comb begin
        st_nxt      = st;
        cnt_nxt     = cnt;
        md_done_nxt = 1'b0;
        case (st)
            IDLE: begin
                if (md_go) begin
                    st_nxt  = MD_BUSY;
                    cnt_nxt = id_md_isdiv ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end
            end
            MD_BUSY: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    st_nxt      = IDLE;
                    md_done_nxt = 1'b1;
                end
            end
            default: begin
                st_nxt  = IDLE;
                cnt_nxt = '0;
            end
        endcase
    end

    // A taken branch outranks any stall since the ID instruction is wrong-path.
    always_comb begin
        pc_stall   = 1'b0;
        ifid_stall = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        md_busy    = 1'b0;
        md_done    = 1'b0;
        if (!rst) begin
            md_busy = (st == MD_BUSY);
            md_done = md_done_q;
            if (ex_branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (stall) begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                idex_flush = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: constant vector table, directed multi-cycle sequences
// and randomized traffic against a cycle-count reference model.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_md_start;
    logic        id_md_isdiv;
    logic        id_md_read;
    logic [4:0]  ex_rw;
    logic        ex_regWr;
    logic [1:0]  ex_memtoreg;
    logic [2:0]  ex_cp0op;
    logic        ex_branch_taken;
    logic        pc_stall;
    logic        ifid_stall;
    logic        ifid_flush;
    logic        idex_flush;
    logic        md_busy;
    logic        md_done;
    logic [31:0] stall_cycles;

    hazard_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_md_start(id_md_start), .id_md_isdiv(id_md_isdiv), .id_md_read(id_md_read),
        .ex_rw(ex_rw), .ex_regWr(ex_regWr), .ex_memtoreg(ex_memtoreg), .ex_cp0op(ex_cp0op),
        .ex_branch_taken(ex_branch_taken),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .md_busy(md_busy), .md_done(md_done),
        .stall_cycles(stall_cycles)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       md_start;
        logic       md_isdiv;
        logic       md_read;
        logic [4:0] ex_rw;
        logic       regwr;
        logic [1:0] m2r;
        logic [2:0] cp0;
        logic       br;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [3:0] ctl;   // {pc_stall, ifid_stall, ifid_flush, idex_flush}
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    logic [5:0] exp_q[$];

    // ---------------- reference model ----------------
    int     busy_left;
    bit     done_flag;
    longint stall_count;
    localparam longint SAT = 64'h0000_0000_FFFF_FFFF;

    function automatic bit model_stall(input stim_t s);
        bit dep;
        bit lu;
        dep = (s.ex_rw != 0) && ((s.urs && s.ex_rw == s.rs) || (s.urt && s.ex_rw == s.rt));
        lu  = dep && ((s.regwr && s.m2r == 2'd1) || s.cp0 == 3'd1);
        return lu || (busy_left > 0 && (s.md_read || s.md_start));
    endfunction

    function automatic logic [5:0] model_out(input stim_t s);
        logic [3:0] ctl;
        if (s.br)                ctl = 4'b0011;
        else if (model_stall(s)) ctl = 4'b1101;
        else                     ctl = 4'b0000;
        return {ctl, busy_left > 0, done_flag};
    endfunction

    task automatic model_step(input stim_t s);
        bit stl;
        stl       = model_stall(s);
        done_flag = 0;
        if (busy_left > 0) begin
            busy_left--;
            done_flag = (busy_left == 0);
        end else if (s.md_start && !s.br && !stl) begin
            busy_left = s.md_isdiv ? 32 : 4;
        end
        if (!s.br && stl)
            stall_count = (stall_count >= SAT) ? SAT : stall_count + 1;
    endtask

    task automatic model_reset();
        busy_left   = 0;
        done_flag   = 0;
        stall_count = 0;
    endtask

    // ---------------- driver tasks ----------------
    function automatic stim_t nop();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t mk(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic urs, input logic urt,
                                 input logic [4:0] rw, input logic regwr,
                                 input logic [1:0] m2r, input logic [2:0] cp0,
                                 input logic br);
        stim_t s;
        s       = nop();
        s.rs    = rs;   s.rt    = rt;
        s.urs   = urs;  s.urt   = urt;
        s.ex_rw = rw;   s.regwr = regwr;
        s.m2r   = m2r;  s.cp0   = cp0;
        s.br    = br;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        id_rs = s.rs; id_rt = s.rt; id_uses_rs = s.urs; id_uses_rt = s.urt;
        id_md_start = s.md_start; id_md_isdiv = s.md_isdiv; id_md_read = s.md_read;
        ex_rw = s.ex_rw; ex_regWr = s.regwr; ex_memtoreg = s.m2r; ex_cp0op = s.cp0;
        ex_branch_taken = s.br;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] dut_out();
        return {pc_stall, ifid_stall, ifid_flush, idex_flush, md_busy, md_done};
    endfunction

    // One pipeline cycle: drive after the falling edge, check, then advance model.
    task automatic run_cycle(input stim_t s, output logic [5:0] got);
        @(negedge clk);
        drive(s);
        #1;
        exp_q.push_back(model_out(s));
        got = dut_out();
        check("outputs", {26'd0, got}, {26'd0, exp_q.pop_front()});
        check("stall_cycles", stall_cycles, stall_count[31:0]);
        @(posedge clk);
        model_step(s);
    endtask

    // ---------------- test ----------------
    vec_t vecs[11];

    initial begin
        logic [5:0] got;
        stim_t      s;
        int         stalls;
        int         dones;
        int         busy;

        vecs[0]  = '{mk(2, 3, 1, 1, 2, 1, 1, 0, 0),   4'b1101};
        vecs[1]  = '{mk(0, 0, 1, 1, 0, 1, 1, 0, 0),   4'b0000};
        vecs[2]  = '{mk(1, 5, 1, 1, 5, 0, 0, 1, 0),   4'b1101};
        vecs[3]  = '{mk(1, 5, 1, 0, 5, 1, 1, 0, 0),   4'b0000};
        vecs[4]  = '{mk(2, 0, 1, 0, 2, 1, 0, 0, 0),   4'b0000};
        vecs[5]  = '{mk(2, 0, 1, 0, 2, 0, 1, 0, 0),   4'b0000};
        vecs[6]  = '{mk(7, 0, 1, 0, 7, 1, 2, 0, 0),   4'b0000};
        vecs[7]  = '{mk(2, 0, 1, 0, 2, 1, 1, 0, 1),   4'b0011};
        vecs[8]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1),   4'b0011};
        vecs[9]  = '{mk(4, 4, 1, 1, 4, 1, 0, 2, 0),   4'b0000};
        vecs[10] = '{mk(9, 31, 1, 1, 31, 1, 1, 0, 0), 4'b1101};

        // Reset with a live load-use hazard on the inputs: outputs must stay 0.
        rst = 1'b1;
        drive(vecs[0].s);
        model_reset();
        #2;
        check("reset_outputs", {26'd0, dut_out()}, 32'd0);
        check("reset_stall_cycles", stall_cycles, 32'd0);
        @(negedge clk);
        drive(nop());
        rst = 1'b0;

        // Constant vector table, state IDLE throughout.
        for (int i = 0; i < 11; i++) begin
            run_cycle(vecs[i].s, got);
            check($sformatf("vec%0d_ctl", i), {28'd0, got[5:2]}, {28'd0, vecs[i].ctl});
        end
        run_cycle(nop(), got);

        // mult issued, mflo waits in ID until the window closes.
        s = nop(); s.md_start = 1'b1;
        run_cycle(s, got);
        s = nop(); s.md_read = 1'b1;
        stalls = 0; dones = 0; busy = 0;
        for (int i = 0; i < 20; i++) begin
            run_cycle(s, got);
            if (got[5]) stalls++;
            if (got[1]) busy++;
            if (got[0]) dones++;
            if (!got[5]) break;
        end
        check("mflo_stall_cycles", stalls, 4);
        check("mult_busy_cycles", busy, 4);
        check("mult_done_pulses", dones, 1);
        run_cycle(nop(), got);
        check("done_single_pulse", {31'd0, got[0]}, 32'd0);

        // Back-to-back mult: the second starts on the IDLE cycle of the first.
        s = nop(); s.md_start = 1'b1;
        run_cycle(s, got);
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            run_cycle(s, got);
            if (got[5]) stalls++;
            else break;
        end
        check("mult2_stall_cycles", stalls, 4);
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            run_cycle(nop(), got);
            if (got[1]) busy++;
            else break;
        end
        check("mult2_busy_cycles", busy, 4);
        run_cycle(nop(), got);

        // div issued, then a branch plus load-use plus wrong-path mult together.
        s = nop(); s.md_start = 1'b1; s.md_isdiv = 1'b1;
        run_cycle(s, got);
        s = mk(2, 0, 1, 0, 2, 1, 1, 0, 1); s.md_start = 1'b1;
        run_cycle(s, got);
        check("branch_over_stall", {28'd0, got[5:2]}, 32'b0011);
        busy = 1;
        for (int i = 0; i < 50; i++) begin
            run_cycle(nop(), got);
            if (got[1]) busy++;
            else break;
        end
        check("div_busy_cycles", busy, 32);

        // Reset at cycle 10 of a div abandons the window.
        s = nop(); s.md_start = 1'b1; s.md_isdiv = 1'b1;
        run_cycle(s, got);
        for (int i = 0; i < 9; i++) run_cycle(nop(), got);
        check("div_busy_pre_reset", {31'd0, md_busy}, 32'd1);
        @(negedge clk);
        drive(vecs[0].s);
        rst = 1'b1;
        #1;
        model_reset();
        check("midreset_outputs", {26'd0, dut_out()}, 32'd0);
        check("midreset_stall_cycles", stall_cycles, 32'd0);
        @(negedge clk);
        drive(nop());
        rst = 1'b0;
        s = nop(); s.md_read = 1'b1;
        run_cycle(s, got);
        check("mfhi_after_reset", {30'd0, got[5], got[1]}, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            s          = nop();
            s.rs       = 5'($urandom_range(0, 3));
            s.rt       = 5'($urandom_range(0, 3));
            s.urs      = 1'($urandom_range(0, 1));
            s.urt      = 1'($urandom_range(0, 1));
            s.md_start = ($urandom_range(0, 7) == 0);
            s.md_isdiv = ($urandom_range(0, 3) == 0);
            s.md_read  = ($urandom_range(0, 5) == 0);
            s.ex_rw    = 5'($urandom_range(0, 3));
            s.regwr    = 1'($urandom_range(0, 1));
            s.m2r      = 2'($urandom_range(0, 3));
            s.cp0      = 3'($urandom_range(0, 2));
            s.br       = ($urandom_range(0, 9) == 0);
            run_cycle(s, got);
        end

        // Saturation: preload the counter just below the top, then keep stalling.
        for (int i = 0; i < 40; i++) run_cycle(nop(), got);
        #1;
        force dut.stall_cycles = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cycles;
        stall_count = 64'h0000_0000_FFFF_FFFD;
        for (int i = 0; i < 5; i++) run_cycle(vecs[0].s, got);
        run_cycle(nop(), got);
        check("stall_cycles_saturated", stall_cycles, 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
